// File: rtl/motor_step_scheduler.sv
// ============================================================================
//  Module   : motor_step_scheduler
//  Shares one step-pulse timing engine between the theta and phi drivers.
//  Optional homing inputs are enabled with `define MOTOR_HOME_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module motor_step_scheduler #(
  parameter int CLK_DIV    = 50000,
  parameter int PULSE_W    = 100,
  parameter int SETTLE_CYC = 2000,
  parameter int THETA_MAX  = 180,
  parameter int PHI_MAX    = 360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_theta_pos,
  input  logic [1:0]  req_theta_neg,
  input  logic [1:0]  req_phi_pos,
  input  logic [1:0]  req_phi_neg,
`ifdef MOTOR_HOME_EN
  input  logic        home_theta_n,
  input  logic        home_phi_n,
`endif
  output logic        step_theta,
  output logic        dir_theta,
  output logic        step_phi,
  output logic        dir_phi,
  output logic [15:0] theta_actual,
  output logic [15:0] phi_actual,
  output logic        busy,
  output logic        at_limit,
  output logic        conflict
);

  localparam int c_CNT_MAX = (CLK_DIV > SETTLE_CYC) ? CLK_DIV : SETTLE_CYC;
  localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CW-1:0] c_SETTLE_LD = c_CW'(SETTLE_CYC - 1);
  localparam logic [c_CW-1:0] c_HI_LD     = c_CW'(PULSE_W - 1);
  localparam logic [c_CW-1:0] c_LO_LD     = c_CW'(CLK_DIV - PULSE_W - 1);
  localparam logic [15:0]     c_THETA_MAX = 16'(THETA_MAX);
  localparam logic [15:0]     c_PHI_TOP   = 16'(PHI_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_STEP_HI = 2'd2,
    S_STEP_LO = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_load;
  // Axis encoding: 0 = theta, 1 = phi
  logic              r_gnt_axis;
  logic              r_gnt_dir;
  logic              r_last_axis;
  logic              r_last_dir;
  logic              r_dir_theta;
  logic              r_dir_phi;
  logic [15:0]       r_theta;
  logic [15:0]       r_phi;
  logic              r_at_limit;
  logic              r_conflict;

  logic w_home_theta;
  logic w_home_phi;
  logic w_tp, w_tn, w_pp, w_pn;
  logic w_theta_conf, w_phi_conf;
  logic w_theta_refuse;
  logic w_theta_valid, w_phi_valid;
  logic w_any;
  logic w_g_axis, w_g_dir, w_match;
  logic w_done;
  logic w_arb;
  logic w_enter_hi;
  logic w_step_axis, w_step_dir;
  logic [15:0] w_theta_nxt;
  logic [15:0] w_phi_nxt;

`ifdef MOTOR_HOME_EN
  logic [1:0] r_hth_sync;
  logic [1:0] r_hph_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hth_sync <= 2'b11;
      r_hph_sync <= 2'b11;
    end else begin
      r_hth_sync <= {r_hth_sync[0], home_theta_n};
      r_hph_sync <= {r_hph_sync[0], home_phi_n};
    end
  end

  assign w_home_theta = ~r_hth_sync[1];
  assign w_home_phi   = ~r_hph_sync[1];
`else
  assign w_home_theta = 1'b0;
  assign w_home_phi   = 1'b0;
`endif

  // Request qualification: only the exact code 2'b01 is a request
  assign w_tp = (req_theta_pos == 2'b01);
  assign w_tn = (req_theta_neg == 2'b01);
  assign w_pp = (req_phi_pos   == 2'b01);
  assign w_pn = (req_phi_neg   == 2'b01);

  assign w_theta_conf   = w_tp & w_tn;
  assign w_phi_conf     = w_pp & w_pn;
  assign w_theta_refuse = (w_tp & ~w_tn & (r_theta >= c_THETA_MAX)) |
                          (w_tn & ~w_tp & ((r_theta == 16'd0) | w_home_theta));
  assign w_theta_valid  = (w_tp ^ w_tn) & ~w_theta_refuse;
  assign w_phi_valid    = w_pp ^ w_pn;
  assign w_any          = w_theta_valid | w_phi_valid;

  // Round-robin: with both axes valid, the axis not stepped last wins
  assign w_g_axis = (w_theta_valid & w_phi_valid) ? ~r_last_axis : w_phi_valid;
  assign w_g_dir  = w_g_axis ? w_pp : w_tp;
  assign w_match  = (w_g_axis == r_last_axis) && (w_g_dir == r_last_dir);
  assign w_done   = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    w_arb  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_arb = 1'b1;
        if (w_any) w_next = w_match ? S_STEP_HI : S_SETTLE;
      end
      S_SETTLE: begin
        if (w_done) w_next = S_STEP_HI;
      end
      S_STEP_HI: begin
        if (w_done) w_next = S_STEP_LO;
      end
      S_STEP_LO: begin
        if (w_done) begin
          w_arb = 1'b1;
          if (w_any) w_next = w_match ? S_STEP_HI : S_SETTLE;
          else       w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = '0;
    case (w_next)
      S_SETTLE:  w_load = c_SETTLE_LD;
      S_STEP_HI: w_load = c_HI_LD;
      S_STEP_LO: w_load = c_LO_LD;
      default:   w_load = '0;
    endcase
  end

  // A step entered from SETTLE uses the latched grant; otherwise it is granted this cycle
  assign w_enter_hi  = (w_next == S_STEP_HI) && (r_state != S_STEP_HI);
  assign w_step_axis = (r_state == S_SETTLE) ? r_gnt_axis : w_g_axis;
  assign w_step_dir  = (r_state == S_SETTLE) ? r_gnt_dir  : w_g_dir;

  always_comb begin
    w_theta_nxt = r_theta;
    if (w_step_dir) begin
      if (r_theta < c_THETA_MAX) w_theta_nxt = r_theta + 16'd1;
    end else begin
      if (r_theta != 16'd0) w_theta_nxt = r_theta - 16'd1;
    end
  end

  always_comb begin
    w_phi_nxt = r_phi;
    if (w_step_dir) w_phi_nxt = (r_phi >= c_PHI_TOP) ? 16'd0 : r_phi + 16'd1;
    else            w_phi_nxt = (r_phi == 16'd0) ? c_PHI_TOP : r_phi - 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_gnt_axis  <= 1'b0;
      r_gnt_dir   <= 1'b0;
      r_last_axis <= 1'b1;
      r_last_dir  <= 1'b0;
      r_dir_theta <= 1'b0;
      r_dir_phi   <= 1'b0;
      r_theta     <= 16'd0;
      r_phi       <= 16'd0;
      r_at_limit  <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= w_load;
      else if (!w_done)      r_cnt <= r_cnt - 1'b1;

      r_at_limit <= w_arb & w_theta_refuse;
      r_conflict <= w_arb & (w_theta_conf | w_phi_conf);

      if (w_arb && w_any) begin
        r_gnt_axis  <= w_g_axis;
        r_gnt_dir   <= w_g_dir;
        r_last_axis <= w_g_axis;
        r_last_dir  <= w_g_dir;
        if (w_g_axis) r_dir_phi   <= w_g_dir;
        else          r_dir_theta <= w_g_dir;
      end

      // Homing overrides any step update in the same cycle
      if (w_home_theta)                    r_theta <= 16'd0;
      else if (w_enter_hi && !w_step_axis) r_theta <= w_theta_nxt;

      if (w_home_phi)                      r_phi <= 16'd0;
      else if (w_enter_hi && w_step_axis)  r_phi <= w_phi_nxt;
    end
  end

  assign step_theta   = (r_state == S_STEP_HI) && !r_gnt_axis;
  assign step_phi     = (r_state == S_STEP_HI) &&  r_gnt_axis;
  assign dir_theta    = r_dir_theta;
  assign dir_phi      = r_dir_phi;
  assign theta_actual = r_theta;
  assign phi_actual   = r_phi;
  assign busy         = (r_state != S_IDLE);
  assign at_limit     = r_at_limit;
  assign conflict     = r_conflict;

endmodule

`default_nettype wire
